gate_truth_table_checker: RTL

GATE_TRUTH_TABLE_CHECKER -- requirements
Module: gate_truth_table_checker

---
 rtl/gate_test_pkg.sv | 15 +
 rtl/settle_timer.sv | 45 ++++
 rtl/gate_truth_table_checker.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/gate_test_pkg.sv
// Purpose : shared types and constants for the gate truth-table checker.
// Contents: chk_state_t  - checker FSM states
//           SETTLE_W     - width of the settle counter
package gate_test_pkg;

   localparam int unsigned SETTLE_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } chk_state_t;

endpackage : gate_test_pkg

// File: rtl/settle_timer.sv
// Purpose : down-counter that times how long a stimulus vector settles
//           before the gate output is sampled.
// Ports   : clk, reset   - clock, asynchronous active-high reset
//           load_i       - load load_val_i into the counter (wins over en_i)
//           en_i         - decrement the counter by one (stops at zero)
//           load_val_i   - value loaded on load_i
//           expired_o    - registered flag, high while the counter holds 1
module settle_timer
   import gate_test_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load_i,
   input  logic                en_i,
   input  logic [SETTLE_W-1:0] load_val_i,
   output logic                expired_o
);

   logic [SETTLE_W-1:0] count_q, count_d;
   logic                expired_q;

   // Next count: load has priority, decrement saturates at zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - SETTLE_W'(1);
      end
   end

   // Expired is registered from the next count so it lines up with count_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         expired_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         expired_q <= (count_d == SETTLE_W'(1));
      end
   end

   assign expired_o = expired_q;

endmodule : settle_timer

// File: rtl/gate_truth_table_checker.sv
// Purpose : walks every input vector of an external gate, waits for it to
//           settle, samples the gate output and compares it against a golden
//           truth table latched at start.
// Ports   : clk, reset        - clock, asynchronous active-high reset
//           start            - begin a run (only honoured in IDLE)
//           expected         - golden truth table, bit k = y for vector k
//           stim             - vector driven to the gate inputs
//           y_in             - gate output
//           busy             - run in progress (SETTLE/SAMPLE/DONE)
//           done             - one-cycle pulse in the DONE state
//           pass             - last run had no mismatches
//           fail_mask        - bit k set when vector k mismatched
//           first_fail       - lowest mismatching vector
//           first_fail_valid - at least one mismatch in the last run
module gate_truth_table_checker
   import gate_test_pkg::*;
#(
   parameter int unsigned N_IN          = 2,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [(2**N_IN)-1:0]   expected,
   output logic [N_IN-1:0]        stim,
   input  logic                   y_in,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [(2**N_IN)-1:0]   fail_mask,
   output logic [N_IN-1:0]        first_fail,
   output logic                   first_fail_valid
);

   localparam int unsigned N_VEC    = 2**N_IN;
   localparam logic [N_IN-1:0] LAST_VEC = N_IN'(N_VEC - 1);

   chk_state_t        state_q, state_d;
   logic [N_IN-1:0]   stim_q, stim_d;
   logic [N_VEC-1:0]  exp_q, exp_d;
   logic [N_VEC-1:0]  fail_mask_q, fail_mask_d;
   logic [N_IN-1:0]   first_fail_q, first_fail_d;
   logic              ffv_q, ffv_d;
   logic              pass_q, pass_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              tmr_load_c;
   logic              tmr_en_c;
   logic              tmr_expired;

   settle_timer u_settle_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmr_load_c),
      .en_i       (tmr_en_c),
      .load_val_i (SETTLE_W'(SETTLE_CYCLES)),
      .expired_o  (tmr_expired)
   );

   // Next-state and result update logic.
   always_comb begin
      state_d      = state_q;
      stim_d       = stim_q;
      exp_d        = exp_q;
      fail_mask_d  = fail_mask_q;
      first_fail_d = first_fail_q;
      ffv_d        = ffv_q;
      pass_d       = pass_q;
      tmr_load_c   = 1'b0;
      tmr_en_c     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = SETTLE;
               exp_d        = expected;
               stim_d       = '0;
               fail_mask_d  = '0;
               first_fail_d = '0;
               ffv_d        = 1'b0;
               pass_d       = 1'b0;
               tmr_load_c   = 1'b1;
            end
         end

         SETTLE: begin
            // Counter holding 1 marks the last settle cycle.
            if (tmr_expired) begin
               state_d = SAMPLE;
            end else begin
               tmr_en_c = 1'b1;
            end
         end

         SAMPLE: begin
            if (y_in != exp_q[stim_q]) begin
               fail_mask_d[stim_q] = 1'b1;
               // Vectors are walked upward, so the first miss is the lowest.
               if (!ffv_q) begin
                  first_fail_d = stim_q;
                  ffv_d        = 1'b1;
               end
            end
            if (stim_q != LAST_VEC) begin
               state_d    = SETTLE;
               stim_d     = stim_q + N_IN'(1);
               tmr_load_c = 1'b1;
            end else begin
               state_d = DONE;
               pass_d  = ~|fail_mask_d;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         stim_q       <= '0;
         exp_q        <= '0;
         fail_mask_q  <= '0;
         first_fail_q <= '0;
         ffv_q        <= 1'b0;
         pass_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         stim_q       <= stim_d;
         exp_q        <= exp_d;
         fail_mask_q  <= fail_mask_d;
         first_fail_q <= first_fail_d;
         ffv_q        <= ffv_d;
         pass_q       <= pass_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign stim             = stim_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign fail_mask        = fail_mask_q;
   assign first_fail       = first_fail_q;
   assign first_fail_valid = ffv_q;

endmodule : gate_truth_table_checker
